// File: rtl/fp_div_seq_if.sv
// Handshake and result bundle for the sequential single-precision divider.
// Valid/ready contract: a request is taken on a rising clk edge where
// start=1 and busy=0; the result on fp_Z and the flags is valid in the cycle
// where done=1 and stays unchanged until the next done pulse.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        busy;
    logic        done;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        dz;
    logic        nv;
    logic [1:0]  dbg_state;

    // Requester side: drives the operation, observes the result.
    modport master (
        output start, fp_X, fp_Y, r_mode,
        input  busy, done, fp_Z, ovrf, udrf, dz, nv, dbg_state
    );

    // Divider side.
    modport slave (
        input  start, fp_X, fp_Y, r_mode,
        output busy, done, fp_Z, ovrf, udrf, dz, nv, dbg_state
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider.
// Radix-2 restoring division, one quotient bit per cycle, fixed latency of
// 28 cycles from accept to done for every operand class. Subnormal inputs
// are flushed to zero and subnormal results are flushed to signed zero.
module fp_div_seq (
    input  logic          clk,
    input  logic          rst_n,
    fp_div_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [31:0]        x_q;
    logic [31:0]        y_q;
    logic [2:0]         mode_q;
    logic [25:0]        rem_q;
    logic [23:0]        dvs_q;
    // Only the last 25 quotient bits are kept: the leading bit is always 1
    // after normalisation, leaving 23 fraction bits, guard and round.
    logic [24:0]        quo_q;
    logic signed [9:0]  exp_q;
    logic [4:0]         cnt_q;

    logic [31:0]        z_q;
    logic               done_q;
    logic               busy_q;
    logic               ovrf_q;
    logic               udrf_q;
    logic               dz_q;
    logic               nv_q;

    // ------------------------------------------------------------------
    // Operand preparation at accept time
    // ------------------------------------------------------------------
    logic [7:0]         ex_in;
    logic [7:0]         ey_in;
    logic [23:0]        mx_in;
    logic [23:0]        my_in;
    logic               mx_lt;
    logic [25:0]        rem_init;
    logic signed [9:0]  exp_init;

    // Significands and pre-normalised exponent from the incoming operands.
    always_comb begin
        ex_in    = bus.fp_X[30:23];
        ey_in    = bus.fp_Y[30:23];
        mx_in    = {1'b1, bus.fp_X[22:0]};
        my_in    = {1'b1, bus.fp_Y[22:0]};
        mx_lt    = (mx_in < my_in);
        // Pre-shifting a smaller dividend guarantees the first quotient bit
        // is 1, so the quotient never needs post-normalisation.
        rem_init = mx_lt ? {1'b0, mx_in, 1'b0} : {2'b00, mx_in};
        exp_init = $signed({2'b00, ex_in}) - $signed({2'b00, ey_in})
                 + (mx_lt ? 10'sd126 : 10'sd127);
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [25:0]        trial;
    logic               q_bit;
    logic [25:0]        rem_next;

    // Subtract the divisor if it fits, then shift the partial remainder.
    always_comb begin
        trial    = rem_q - {2'b00, dvs_q};
        q_bit    = (rem_q >= {2'b00, dvs_q});
        rem_next = q_bit ? {trial[24:0], 1'b0} : {rem_q[24:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Rounding and special-case selection (consumed in RND)
    // ------------------------------------------------------------------
    logic               sign;
    logic               guard;
    logic               rnd_bit;
    logic               sticky;
    logic               inexact;
    logic               inc;
    logic [23:0]        frac_sum;
    logic signed [9:0]  exp_fin;
    logic               x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [31:0]        z_new;
    logic               ovrf_new, udrf_new, dz_new, nv_new;

    // Round the truncated quotient and pick the final result and flags.
    always_comb begin
        sign    = x_q[31] ^ y_q[31];
        guard   = quo_q[1];
        rnd_bit = quo_q[0];
        // Shifting never loses remainder bits, so nonzero-ness is preserved.
        sticky  = |rem_q;
        inexact = guard | rnd_bit | sticky;

        case (mode_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign & inexact;
            3'b011:  inc = ~sign & inexact;
            3'b100:  inc = guard;
            default: inc = guard & (rnd_bit | sticky | quo_q[2]);
        endcase

        // A carry into bit 23 means the significand overflowed to 2.0; the
        // fraction bits are then all zero by construction.
        frac_sum = {1'b0, quo_q[24:2]} + {23'd0, inc};
        exp_fin  = exp_q + $signed({9'd0, frac_sum[23]});

        x_nan  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
        y_nan  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
        x_inf  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
        y_inf  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
        x_zero = (x_q[30:23] == 8'h00);
        y_zero = (y_q[30:23] == 8'h00);

        z_new    = {sign, exp_fin[7:0], frac_sum[22:0]};
        ovrf_new = 1'b0;
        udrf_new = 1'b0;
        dz_new   = 1'b0;
        nv_new   = 1'b0;

        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            z_new  = 32'h7FC0_0000;
            nv_new = 1'b1;
        end else if (x_inf) begin
            z_new = {sign, 8'hFF, 23'd0};
        end else if (y_zero) begin
            z_new  = {sign, 8'hFF, 23'd0};
            dz_new = 1'b1;
        end else if (y_inf || x_zero) begin
            z_new = {sign, 31'd0};
        end else if (exp_fin >= 10'sd255) begin
            z_new    = {sign, 8'hFF, 23'd0};
            ovrf_new = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            z_new    = {sign, 31'd0};
            udrf_new = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // IDLE -> DIV (26 cycles) -> RND -> DONE -> IDLE; results load on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_q    <= 32'd0;
            y_q    <= 32'd0;
            mode_q <= 3'd0;
            rem_q  <= 26'd0;
            dvs_q  <= 24'd0;
            quo_q  <= 25'd0;
            exp_q  <= 10'sd0;
            cnt_q  <= 5'd0;
            z_q    <= 32'd0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            ovrf_q <= 1'b0;
            udrf_q <= 1'b0;
            dz_q   <= 1'b0;
            nv_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        x_q    <= bus.fp_X;
                        y_q    <= bus.fp_Y;
                        mode_q <= bus.r_mode;
                        rem_q  <= rem_init;
                        dvs_q  <= my_in;
                        quo_q  <= 25'd0;
                        exp_q  <= exp_init;
                        cnt_q  <= 5'd0;
                        busy_q <= 1'b1;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[23:0], q_bit};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd25) begin
                        state <= RND;
                    end
                end
                RND: begin
                    z_q    <= z_new;
                    ovrf_q <= ovrf_new;
                    udrf_q <= udrf_new;
                    dz_q   <= dz_new;
                    nv_q   <= nv_new;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fp_Z      = z_q;
    assign bus.ovrf      = ovrf_q;
    assign bus.udrf      = udrf_q;
    assign bus.dz        = dz_q;
    assign bus.nv        = nv_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vector table with random gaps,
// back-to-back start, and reset in the middle of an operation.
module tb_fp_div_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errs;
    int   done_cnt;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Expected {fp_Z, ovrf, udrf, dz, nv} and accept cycle per accepted request.
    logic [35:0] exp_q[$];
    int          acc_q[$];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  mode;
        logic [31:0] z;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[23];

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: compare every done against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                check_val("result", {28'd0, bus.fp_Z, bus.ovrf, bus.udrf, bus.dz, bus.nv},
                          {28'd0, exp_q.pop_front()});
                check_val("latency", 64'(cyc - acc_q.pop_front()), 64'd28);
            end
        end
    end

    // Driver: one request from an idle negedge, then wait for its done.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] mode,
                          input logic [31:0] z, input logic [3:0] flags);
        bit seen;
        repeat ($urandom_range(3, 0)) @(negedge clk);
        bus.start  = 1'b1;
        bus.fp_X   = x;
        bus.fp_Y   = y;
        bus.r_mode = mode;
        exp_q.push_back({z, flags});
        acc_q.push_back(cyc);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.fp_X   = $urandom;
        bus.fp_Y   = $urandom;
        bus.r_mode = 3'($urandom_range(7, 0));
        check_val("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check_val("timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 4'b0000};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 4'b0000};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 4'b0000};
        vecs[4]  = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 4'b0000};
        vecs[5]  = '{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 4'b0000};
        vecs[6]  = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 4'b0000};
        vecs[7]  = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 4'b0000};
        vecs[8]  = '{32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 4'b1000};
        vecs[9]  = '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 4'b0100};
        vecs[10] = '{32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 4'b0000};
        vecs[11] = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 4'b0010};
        vecs[12] = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 4'b0001};
        vecs[13] = '{32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 4'b0001};
        vecs[14] = '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 4'b0001};
        vecs[15] = '{32'h40000000, 32'h40000000, 3'd0, 32'h3F800000, 4'b0000};
        vecs[16] = '{32'hC0400000, 32'h40000000, 3'd0, 32'hBFC00000, 4'b0000};
        vecs[17] = '{32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000, 4'b0000};
        vecs[18] = '{32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 4'b0000};
        vecs[19] = '{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 4'b0000};
        vecs[20] = '{32'h3F800000, 32'h00400000, 3'd0, 32'h7F800000, 4'b0010};
        vecs[21] = '{32'h7F000000, 32'h3F800000, 3'd0, 32'h7F000000, 4'b0000};
        vecs[22] = '{32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F800000, 4'b1000};
    end

    // Main sequence.
    initial begin
        int d0;
        checks     = 0;
        errs       = 0;
        done_cnt   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.fp_X   = 32'd0;
        bus.fp_Y   = 32'd0;
        bus.r_mode = 3'd0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", {27'd0, bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf, bus.dz, bus.nv},
                  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].z, vecs[i].flags);
        end
        // Reserved rounding codes behave as round-to-nearest-even.
        run_op(32'h3F800000, 32'h40400000, 3'($urandom_range(7, 5)), 32'h3EAAAAAB, 4'b0000);

        // start held high: only idle-cycle requests are taken.
        d0 = done_cnt;
        for (int i = 0; i < 58; i++) begin
            bus.start = 1'b1;
            if (!bus.busy) begin
                bus.fp_X   = 32'h40C00000;
                bus.fp_Y   = 32'h40000000;
                bus.r_mode = 3'd0;
                exp_q.push_back({32'h40400000, 4'b0000});
                acc_q.push_back(cyc);
            end else begin
                bus.fp_X   = $urandom;
                bus.fp_Y   = $urandom;
                bus.r_mode = 3'($urandom_range(4, 0));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_val("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        check_val("b2b_idle", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);

        // Reset in the middle of DIV.
        bus.start  = 1'b1;
        bus.fp_X   = 32'h3F800000;
        bus.fp_Y   = 32'h40400000;
        bus.r_mode = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_outs", {27'd0, bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf, bus.dz, bus.nv},
                  64'd0);
        check_val("abort_state", {62'd0, bus.dbg_state}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000);
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; accepted only while busy=0.
REQ-005 fp_X  input  32  IEEE-754 single dividend, sampled on acceptance.
REQ-006 fp_Y  input  32  IEEE-754 single divisor, sampled on acceptance.
REQ-007 r_mode  input  3  rounding mode, sampled on acceptance: 000 RNE, 001 RTZ, 010 RDN (toward -inf), 011 RUP (toward +inf), 100 RMM (ties away).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 fp_Z  output  32  quotient X/Y.
REQ-011 ovrf, udrf, dz, nv  output  1 each  overflow, underflow, divide-by-zero and invalid flags.

Function
REQ-012 States SHALL be IDLE, DIV, RND and DONE; busy SHALL equal (state != IDLE).
REQ-013 IDLE with start=1 SHALL latch operands and r_mode, then enter DIV; start in any other state SHALL be ignored.
REQ-014 DIV SHALL run exactly 26 cycles of radix-2 restoring division, one quotient bit per cycle, then enter RND.
REQ-015 RND SHALL last one cycle, then enter DONE; DONE SHALL last one cycle, then enter IDLE.
REQ-016 For every operand class, done SHALL be high only in the 28th cycle after the accept cycle.
REQ-017 fp_Z and all flags SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-018 Sign: sign_Z = fp_X[31] XOR fp_Y[31], for all results except the NaN result.
REQ-019 Subnormal inputs (exponent 0) SHALL be treated as signed zero (flush-to-zero); no subnormal SHALL be output.
REQ-020 Significands SHALL be mX={1,frac_X} and mY={1,frac_Y}.
REQ-021 If mX<mY, mX SHALL be shifted left 1 and the biased exponent SHALL be eX-eY+126; otherwise it SHALL be eX-eY+127.
REQ-022 The quotient SHALL have 24 significand bits plus guard and round bits; sticky SHALL be (final remainder != 0).
REQ-023 RNE SHALL increment on guard & (round|sticky|lsb); RTZ SHALL never increment.
REQ-024 RDN SHALL increment when sign=1 and the result is inexact; RUP SHALL increment when sign=0 and the result is inexact.
REQ-025 RMM SHALL increment when guard=1; codes 101-111 SHALL behave as RNE.
REQ-026 A rounding carry out of the significand SHALL zero the fraction and add 1 to the exponent.
REQ-027 Final exponent >=255 SHALL give {sign,8'hFF,23'b0} with ovrf=1.
REQ-028 Final exponent <=0 SHALL give {sign,31'b0} with udrf=1.
REQ-029 A NaN input, 0/0 or inf/inf SHALL give 32'h7FC00000 with nv=1.
REQ-030 Finite nonzero / zero SHALL give signed inf with dz=1.
REQ-031 inf/finite SHALL give signed inf, and finite/inf or zero/nonzero-finite SHALL give signed zero, all with flags 0.
REQ-032 Special cases SHALL still traverse DIV/RND, preserving fixed latency.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE and set busy, done, fp_Z, ovrf, udrf, dz and nv to 0, including mid-operation.
REQ-034 After reset deassertion, the first start SHALL be accepted normally, with no residue from an aborted operation.

Verification
REQ-035 X=40C00000, Y=40000000, RNE -> fp_Z=40400000, flags 0, done exactly 28 cycles after accept.
REQ-036 X=3F800000, Y=40400000 -> RNE 3EAAAAAB; RTZ 3EAAAAAA; RMM 3EAAAAAB; with X=BF800000: RDN BEAAAAAB, RUP BEAAAAAA.
REQ-037 X=7F7FFFFF, Y=3F000000 -> 7F800000, ovrf=1; X=00800000, Y=40000000 -> 00000000, udrf=1; X=00400000 (subnormal), Y=3F800000 -> 00000000, flags 0.
REQ-038 X=3F800000, Y=00000000 -> 7F800000, dz=1; 0/0, 7F800000/FF800000 and 7FC00001/3F800000 -> 7FC00000, nv=1.
REQ-039 start re-asserted every cycle while busy -> exactly one done per 29 cycles, operands of the first accept used.
REQ-040 rst_n pulsed low at DIV cycle 10 -> all outputs 0 at once; a following 40C00000/40000000 -> 40400000 after 28 cycles.
